// File: rtl/sys_bus_responder_if.sv
// sys_bus_responder_if
//   System-bus bundle between a requester (master) and the responder model (slave).
//   Signal names keep the responder's point of view (_i into the responder, _o out of it).
//   Signals:
//     sys_addr_i   SYS_AW  byte address
//     sys_wdata_i  SYS_DW  write data
//     sys_sel_i    SYS_SW  byte enables
//     sys_wen_i    1       write request pulse
//     sys_ren_i    1       read request pulse
//     sys_rdata_o  SYS_DW  read data, valid with a read ack
//     sys_err_o    1       error flag, valid with ack
//     sys_ack_o    1       one-cycle completion pulse
interface sys_bus_responder_if #(
    parameter int SYS_DW = 64,
    parameter int SYS_AW = 32,
    parameter int SYS_SW = SYS_DW / 8
);
    logic [SYS_AW-1:0] sys_addr_i;
    logic [SYS_DW-1:0] sys_wdata_i;
    logic [SYS_SW-1:0] sys_sel_i;
    logic              sys_wen_i;
    logic              sys_ren_i;
    logic [SYS_DW-1:0] sys_rdata_o;
    logic              sys_err_o;
    logic              sys_ack_o;

    modport master (
        output sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
        input  sys_rdata_o, sys_err_o, sys_ack_o
    );

    modport slave (
        input  sys_addr_i, sys_wdata_i, sys_sel_i, sys_wen_i, sys_ren_i,
        output sys_rdata_o, sys_err_o, sys_ack_o
    );
endinterface

// File: rtl/sys_bus_responder.sv
// sys_bus_responder
//   Target-side model of a system bus: a word-addressed RAM behind a
//   request/ack handshake with fixed (optionally jittered) ack latency and
//   address-range / alignment error responses.
//   Ports:
//     axi_clk_i   in   clock, rising edge
//     axi_rstn_i  in   async active-low reset
//     bus         slave modport of sys_bus_responder_if (request in, ack/rdata/err out)
//     busy_o      out  request in flight (FSM not IDLE)
//     viol_o      out  sticky protocol-violation flag, cleared only by reset
//     req_cnt_o   out  accepted-request count, wraps
//   Optional feature: define SYS_RESP_JITTER_EN to add 0..3 extra wait cycles
//   per request from an 8-bit LFSR (seed 8'hA5).
module sys_bus_responder #(
    parameter int                SYS_DW    = 64,
    parameter int                SYS_AW    = 32,
    parameter int                SYS_SW    = SYS_DW / 8,
    parameter int                MEM_DEPTH = 256,
    parameter logic [SYS_AW-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int                ACK_LAT   = 2
) (
    input  logic                 axi_clk_i,
    input  logic                 axi_rstn_i,
    sys_bus_responder_if.slave   bus,
    output logic                 busy_o,
    output logic                 viol_o,
    output logic [15:0]          req_cnt_o
);
    localparam int                ALSB      = $clog2(SYS_SW);
    localparam int                IDXW      = $clog2(MEM_DEPTH);
    localparam logic [SYS_AW:0]   MEM_BYTES = (SYS_AW+1)'(MEM_DEPTH * SYS_SW);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [SYS_AW-1:0]   r_addr;
    logic [SYS_DW-1:0]   r_wdata;
    logic [SYS_SW-1:0]   r_sel;
    logic                r_wr, r_rd;
    logic [4:0]          r_lat_cnt;
    logic [1:0]          r_extra;
    logic                r_ack, r_err, r_viol;
    logic [SYS_DW-1:0]   r_rdata;
    logic [15:0]         r_req_cnt;
    logic [SYS_DW-1:0]   r_mem [MEM_DEPTH];

    logic                w_req, w_accept, w_wait_done, w_drop, w_err, w_do_write;
    logic [SYS_AW-1:0]   w_off;
    logic [IDXW-1:0]     w_idx;
    logic [4:0]          w_lat_tgt;
    logic [1:0]          w_jit;

    assign w_req = bus.sys_wen_i | bus.sys_ren_i;

`ifdef SYS_RESP_JITTER_EN
    // x^8+x^6+x^5+x^4+1, stepped once per accepted request
    logic [7:0] r_lfsr;
    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i)
            r_lfsr <= 8'hA5;
        else if (w_accept)
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_jit = r_lfsr[1:0];
`else
    assign w_jit = 2'b00;
`endif

    // Exit WAIT after (ACK_LAT-1+extra) counts so ack lands ACK_LAT+extra edges after sampling.
    assign w_lat_tgt = 5'(ACK_LAT - 1) + {3'b000, r_extra};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wait_done = 1'b0;
        case (r_state)
            IDLE: if (w_req) begin
                w_state_nxt = WAIT;
                w_accept    = 1'b1;
            end
            WAIT: if (r_lat_cnt == w_lat_tgt) begin
                w_state_nxt = RESP;
                w_wait_done = 1'b1;
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_drop = w_req && (r_state != IDLE);

    // Decode the latched request; the subtraction wraps so addresses below
    // BASE_ADDR land far out of range.
    assign w_off      = r_addr - BASE_ADDR;
    assign w_idx      = w_off[ALSB +: IDXW];
    assign w_err      = ({1'b0, w_off} >= MEM_BYTES) || (w_off[ALSB-1:0] != '0) ||
                        (r_wr && r_rd);
    // RAM is only touched on the edge that enters RESP, so a reset before the
    // ack cannot leave a partial write behind.
    assign w_do_write = w_wait_done && r_wr && !w_err;

    always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
        if (!axi_rstn_i) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_sel     <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_lat_cnt <= '0;
            r_extra   <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_viol    <= 1'b0;
            r_rdata   <= '0;
            r_req_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr    <= bus.sys_addr_i;
                r_wdata   <= bus.sys_wdata_i;
                r_sel     <= bus.sys_sel_i;
                r_wr      <= bus.sys_wen_i;
                r_rd      <= bus.sys_ren_i;
                r_lat_cnt <= '0;
                r_extra   <= w_jit;
                r_req_cnt <= r_req_cnt + 16'd1;
            end else if (r_state == WAIT) begin
                r_lat_cnt <= r_lat_cnt + 5'd1;
            end
            if (w_drop || (w_accept && bus.sys_wen_i && bus.sys_ren_i))
                r_viol <= 1'b1;
            r_ack <= w_wait_done;
            r_err <= w_wait_done && w_err;
            if (w_wait_done && r_rd)
                r_rdata <= w_err ? '0 : r_mem[w_idx];
        end
    end

    // RAM has no reset: contents survive axi_rstn_i.
    always_ff @(posedge axi_clk_i) begin
        if (w_do_write)
            for (int b = 0; b < SYS_SW; b++)
                if (r_sel[b])
                    r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
    end

    assign bus.sys_ack_o   = r_ack;
    assign bus.sys_err_o   = r_err;
    assign bus.sys_rdata_o = r_rdata;
    assign busy_o          = (r_state != IDLE);
    assign viol_o          = r_viol;
    assign req_cnt_o       = r_req_cnt;
endmodule
